alu_exec_unit: RTL and testbench

- Execute-stage ALU datapath that consumes the 4-bit ALU control code and the two operands, and produces a registered result plus NZCV flags.
- Uses a valid/ready handshake on both input and output, so the pipeline can stall.
- Single-cycle for logic and arithmetic codes; multi-cycle iterative for shift codes. Sits directly after the ALU control decoder in stage 3.

---
 rtl/alu_exec_unit_pkg.sv | 31 +++
 rtl/alu_exec_unit_shifter.sv | 62 ++++++
 rtl/alu_exec_unit.sv | 156 +++++++++++++++
 tb/tb_alu_exec_unit.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_exec_unit_pkg.sv
// Shared ALU control codes, FSM state encoding and flag bundle for the execute-stage ALU.
// Shift support is compiled in only when ALU_EXEC_SHIFT_EN is defined.
package alu_exec_unit_pkg;

   localparam logic [3:0] ALU_AND   = 4'b0000;
   localparam logic [3:0] ALU_ORR   = 4'b0001;
   localparam logic [3:0] ALU_ADD   = 4'b0010;
   localparam logic [3:0] ALU_LSL   = 4'b0011;
   localparam logic [3:0] ALU_LSR   = 4'b0100;
   localparam logic [3:0] ALU_SUB   = 4'b0110;
   localparam logic [3:0] ALU_PASSB = 4'b0111;
   localparam logic [3:0] ALU_NOR   = 4'b1100;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_HOLD  = 2'd2
   } alu_state_e;

   typedef struct packed {
      logic n;
      logic z;
      logic c;
      logic v;
   } alu_flags_t;

   function automatic logic is_shift_code(input logic [3:0] code);
      return (code == ALU_LSL) || (code == ALU_LSR);
   endfunction

endpackage

// File: rtl/alu_exec_unit_shifter.sv
// Iterative one-bit-per-cycle logical shifter; done_o marks the cycle whose edge
// produces the final shifted value on data_o.
module alu_iter_shifter
   import alu_exec_unit_pkg::*;
#(
   parameter int DATA_W  = 64,
   parameter int SHAMT_W = 6
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start_i,
   input  logic               left_i,
   input  logic [DATA_W-1:0]  data_i,
   input  logic [SHAMT_W-1:0] shamt_i,
   output logic [DATA_W-1:0]  data_o,
   output logic               done_o
);

   logic [DATA_W-1:0]  data_q, data_d;
   logic [SHAMT_W-1:0] cnt_q, cnt_d;
   logic               left_q, left_d;
   logic               active_q, active_d;
   logic [DATA_W-1:0]  shift_next;

   assign shift_next = left_q ? {data_q[DATA_W-2:0], 1'b0} : {1'b0, data_q[DATA_W-1:1]};
   assign data_o     = shift_next;
   assign done_o     = active_q && (cnt_q == SHAMT_W'(1));

   always_comb begin
      data_d   = data_q;
      cnt_d    = cnt_q;
      left_d   = left_q;
      active_d = active_q;
      if (start_i) begin
         data_d   = data_i;
         cnt_d    = shamt_i;
         left_d   = left_i;
         active_d = (shamt_i != '0);
      end else if (active_q) begin
         data_d = shift_next;
         cnt_d  = cnt_q - SHAMT_W'(1);
         if (cnt_q == SHAMT_W'(1)) begin
            active_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_q   <= '0;
         cnt_q    <= '0;
         left_q   <= 1'b0;
         active_q <= 1'b0;
      end else begin
         data_q   <= data_d;
         cnt_q    <= cnt_d;
         left_q   <= left_d;
         active_q <= active_d;
      end
   end

endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU with valid/ready on both sides, registered result and NZCV flags.
// Define ALU_EXEC_SHIFT_EN to enable the iterative LSL/LSR path (otherwise they execute as ADD).
module alu_exec_unit
   import alu_exec_unit_pkg::*;
#(
   parameter int DATA_W  = 64,
   parameter int SHAMT_W = 6
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [3:0]         control_bits,
   input  logic [DATA_W-1:0]  operand_a,
   input  logic [DATA_W-1:0]  operand_b,
   input  logic [SHAMT_W-1:0] shamt,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [DATA_W-1:0]  result,
   output logic               flag_n,
   output logic               flag_z,
   output logic               flag_c,
   output logic               flag_v,
   output logic               busy
);

   alu_state_e        state_q, state_d;
   logic [DATA_W-1:0] result_q, result_d;
   alu_flags_t        flags_q, flags_d;
   logic              out_valid_q, out_valid_d;
   logic              accept;
   logic              sub_op, alu_c, alu_v;
   logic [DATA_W-1:0] b_eff, alu_res;
   logic [DATA_W:0]   sum_w;

   assign in_ready = rst_n && (state_q == ST_IDLE) && (!out_valid_q || out_ready);
   assign accept   = in_valid && in_ready;

   // SUB reuses the adder as a + ~b + 1, so carry-out doubles as no-borrow
   always_comb begin
      sub_op  = (control_bits == ALU_SUB);
      b_eff   = sub_op ? ~operand_b : operand_b;
      sum_w   = {1'b0, operand_a} + {1'b0, b_eff} + {{DATA_W{1'b0}}, sub_op};
      alu_res = sum_w[DATA_W-1:0];
      alu_c   = sum_w[DATA_W];
      alu_v   = (operand_a[DATA_W-1] == b_eff[DATA_W-1]) &&
                (sum_w[DATA_W-1] != operand_a[DATA_W-1]);
      case (control_bits)
         ALU_AND:   begin alu_res = operand_a & operand_b;    alu_c = 1'b0; alu_v = 1'b0; end
         ALU_ORR:   begin alu_res = operand_a | operand_b;    alu_c = 1'b0; alu_v = 1'b0; end
         ALU_PASSB: begin alu_res = operand_b;                alu_c = 1'b0; alu_v = 1'b0; end
         ALU_NOR:   begin alu_res = ~(operand_a | operand_b); alu_c = 1'b0; alu_v = 1'b0; end
`ifdef ALU_EXEC_SHIFT_EN
         ALU_LSL, ALU_LSR: begin alu_res = operand_a; alu_c = 1'b0; alu_v = 1'b0; end
`endif
         default: ;
      endcase
   end

`ifdef ALU_EXEC_SHIFT_EN
   logic              shift_start, shift_done;
   logic [DATA_W-1:0] shift_res;

   assign shift_start = accept && is_shift_code(control_bits) && (shamt != '0);
   assign busy        = (state_q == ST_SHIFT);

   alu_iter_shifter #(
      .DATA_W (DATA_W),
      .SHAMT_W(SHAMT_W)
   ) u_shifter (
      .clk    (clk),
      .rst_n  (rst_n),
      .start_i(shift_start),
      .left_i (control_bits == ALU_LSL),
      .data_i (operand_a),
      .shamt_i(shamt),
      .data_o (shift_res),
      .done_o (shift_done)
   );
`else
   logic unused_shamt;
   assign unused_shamt = ^shamt;
   assign busy         = 1'b0;
`endif

   always_comb begin
      state_d     = state_q;
      result_d    = result_q;
      flags_d     = flags_q;
      out_valid_d = out_valid_q;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
`ifdef ALU_EXEC_SHIFT_EN
               if (shift_start) begin
                  state_d     = ST_SHIFT;
                  out_valid_d = 1'b0;
               end else
`endif
               begin
                  result_d    = alu_res;
                  flags_d.n   = alu_res[DATA_W-1];
                  flags_d.z   = (alu_res == '0);
                  flags_d.c   = alu_c;
                  flags_d.v   = alu_v;
                  out_valid_d = 1'b1;
               end
            end else if (out_ready) begin
               out_valid_d = 1'b0;
            end
         end
`ifdef ALU_EXEC_SHIFT_EN
         ST_SHIFT: begin
            if (shift_done) begin
               result_d    = shift_res;
               flags_d.n   = shift_res[DATA_W-1];
               flags_d.z   = (shift_res == '0);
               flags_d.c   = 1'b0;
               flags_d.v   = 1'b0;
               out_valid_d = 1'b1;
               state_d     = ST_HOLD;
            end
         end
`endif
         ST_HOLD: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               state_d     = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         result_q    <= '0;
         flags_q     <= '0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         result_q    <= result_d;
         flags_q     <= flags_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign out_valid = out_valid_q;
   assign result    = result_q;
   assign flag_n    = flags_q.n;
   assign flag_z    = flags_q.z;
   assign flag_c    = flags_q.c;
   assign flag_v    = flags_q.v;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Scoreboard bench for alu_exec_unit: directed vectors, back-pressure, reset and random ops.
module tb_alu_exec_unit;
   import alu_exec_unit_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [3:0]  control_bits = '0;
   logic [63:0] operand_a = '0;
   logic [63:0] operand_b = '0;
   logic [5:0]  shamt = '0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [63:0] result;
   logic        flag_n, flag_z, flag_c, flag_v;
   logic        busy;

   typedef struct packed {
      logic [63:0] res;
      logic [3:0]  nzcv;
   } exp_t;

   exp_t sb_q[$];
   int   n_checks = 0;
   int   n_fail = 0;
   bit   rand_bp = 1'b0;

   alu_exec_unit #(.DATA_W(64), .SHAMT_W(6)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .control_bits(control_bits),
      .operand_a   (operand_a),
      .operand_b   (operand_b),
      .shamt       (shamt),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .result      (result),
      .flag_n      (flag_n),
      .flag_z      (flag_z),
      .flag_c      (flag_c),
      .flag_v      (flag_v),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%h, expected 0x%h", tag, got, exp);
      end
   endtask

   function automatic exp_t mk(input logic [63:0] r, input logic [3:0] f);
      exp_t e;
      e.res  = r;
      e.nzcv = f;
      return e;
   endfunction

   // Reference model: unsigned compare for borrow, explicit sign rules for overflow.
   function automatic exp_t model(input logic [3:0] code, input logic [63:0] a,
                                  input logic [63:0] b, input logic [5:0] sh);
      logic [64:0] w;
      logic [63:0] r;
      logic        c, v;
      c = 1'b0;
      v = 1'b0;
      case (code)
         ALU_AND:   r = a & b;
         ALU_ORR:   r = a | b;
         ALU_PASSB: r = b;
         ALU_NOR:   r = ~(a | b);
         ALU_SUB: begin
            r = a - b;
            c = (a >= b);
            v = (a[63] != b[63]) && (r[63] != a[63]);
         end
`ifdef ALU_EXEC_SHIFT_EN
         ALU_LSL:   r = a << sh;
         ALU_LSR:   r = a >> sh;
`endif
         default: begin
            w = {1'b0, a} + {1'b0, b};
            r = w[63:0];
            c = w[64];
            v = (a[63] == b[63]) && (r[63] != a[63]);
         end
      endcase
      return mk(r, {r[63], (r == 64'd0), c, v});
   endfunction

   // Present one op; push its expectation once the handshake edge has passed.
   task automatic send(input logic [3:0] code, input logic [63:0] a, input logic [63:0] b,
                       input logic [5:0] sh, input exp_t e, output int waits);
      bit acc;
      acc   = 1'b0;
      waits = 0;
      control_bits = code;
      operand_a    = a;
      operand_b    = b;
      shamt        = sh;
      in_valid     = 1'b1;
      for (int k = 0; k < 400 && !acc; k++) begin
         @(negedge clk);
         acc = in_ready;
         @(posedge clk);
         #1;
         if (acc) sb_q.push_back(e);
         else waits++;
         if (rand_bp) out_ready = 1'($urandom_range(0, 1));
      end
      in_valid = 1'b0;
      if (!acc) check("accept_timeout", 64'(acc), 64'(1));
   endtask

   task automatic send_m(input logic [3:0] code, input logic [63:0] a, input logic [63:0] b,
                         input logic [5:0] sh);
      int w;
      send(code, a, b, sh, model(code, a, b, sh), w);
   endtask

   always @(negedge clk) begin : monitor
      exp_t e;
      if (rst_n && out_valid && out_ready) begin
         if (sb_q.size() == 0) begin
            check("spurious_out", 64'(out_valid), 64'(0));
         end else begin
            e = sb_q.pop_front();
            $display("txn result=0x%h nzcv=%b expected=0x%h/%b", result,
                     {flag_n, flag_z, flag_c, flag_v}, e.res, e.nzcv);
            check("result", result, e.res);
            check("nzcv", 64'({flag_n, flag_z, flag_c, flag_v}), 64'(e.nzcv));
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int w;
      int cnt;
      bit seen;
      logic [3:0] codes [9];
      codes = '{ALU_AND, ALU_ORR, ALU_ADD, ALU_SUB, ALU_PASSB, ALU_NOR, ALU_LSL, ALU_LSR, 4'b1010};

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_in_ready", 64'(in_ready), 64'(0));
      check("rst_out_valid", 64'(out_valid), 64'(0));
      check("rst_result", result, 64'd0);
      check("rst_flags", 64'({flag_n, flag_z, flag_c, flag_v}), 64'(0));
      check("rst_busy", 64'(busy), 64'(0));
      rst_n = 1'b1;
      @(negedge clk);
      check("in_ready_after_rst", 64'(in_ready), 64'(1));
      @(posedge clk);
      #1;

      // Directed vectors with hand-derived expectations
      send(ALU_ADD, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 6'd0, mk(64'h8000_0000_0000_0000, 4'b1001), w);
      @(negedge clk);
      check("add_latency_valid", 64'(out_valid), 64'(1));
      @(posedge clk);
      #1;
      send(ALU_SUB, 64'd5, 64'd5, 6'd0, mk(64'd0, 4'b0110), w);
      send(ALU_SUB, 64'd3, 64'd5, 6'd0, mk(64'hFFFF_FFFF_FFFF_FFFE, 4'b1000), w);
      send(ALU_PASSB, 64'h55, 64'd0, 6'd0, mk(64'd0, 4'b0100), w);
      send(ALU_NOR, 64'd0, 64'd0, 6'd0, mk(64'hFFFF_FFFF_FFFF_FFFF, 4'b1000), w);
      send(ALU_AND, 64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00, 6'd0,
           mk(64'hF000_F000_F000_F000, 4'b1000), w);
      send(ALU_ORR, 64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00, 6'd0,
           mk(64'hFFF0_FFF0_FFF0_FFF0, 4'b1000), w);
      send(ALU_ADD, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 6'd0, mk(64'd0, 4'b0110), w);
      send(4'b1111, 64'd2, 64'd3, 6'd0, mk(64'd5, 4'b0000), w);
      check("back_to_back_waits", 64'(w), 64'(0));
      send(ALU_SUB, 64'h8000_0000_0000_0000, 64'd1, 6'd0,
           mk(64'h7FFF_FFFF_FFFF_FFFF, 4'b0011), w);
      check("back_to_back_waits2", 64'(w), 64'(0));
      repeat (2) @(posedge clk);
      #1;

      // Back-pressure: result held, no new op accepted, then simultaneous consume + accept
      out_ready = 1'b0;
      send(ALU_ADD, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 6'd0, mk(64'h8000_0000_0000_0000, 4'b1001), w);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("bp_valid", 64'(out_valid), 64'(1));
         check("bp_result", result, 64'h8000_0000_0000_0000);
         check("bp_in_ready", 64'(in_ready), 64'(0));
      end
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      send(ALU_SUB, 64'd10, 64'd3, 6'd0, mk(64'd7, 4'b0010), w);
      check("bp_same_cycle_accept", 64'(w), 64'(0));
      repeat (2) @(posedge clk);
      #1;

      // Reset while a result is being held
      out_ready = 1'b0;
      send(ALU_ORR, 64'h1, 64'h2, 6'd0, mk(64'h3, 4'b0000), w);
      @(negedge clk);
      check("hold_before_rst", 64'(out_valid), 64'(1));
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check("async_rst_valid", 64'(out_valid), 64'(0));
      check("async_rst_result", result, 64'd0);
      check("async_rst_in_ready", 64'(in_ready), 64'(0));
      sb_q.delete();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      out_ready = 1'b1;
      cnt = 0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (out_valid) cnt++;
      end
      check("no_stale_after_rst", 64'(cnt), 64'(0));
      check("in_ready_after_rst2", 64'(in_ready), 64'(1));
      @(posedge clk);
      #1;

`ifdef ALU_EXEC_SHIFT_EN
      // Iterative shift: 63 busy cycles, then result
      send(ALU_LSL, 64'd1, 64'd0, 6'd63, mk(64'h8000_0000_0000_0000, 4'b1000), w);
      cnt  = 0;
      seen = 1'b0;
      for (int k = 0; k < 200 && !seen; k++) begin
         @(negedge clk);
         if (k == 0) check("shift_in_ready", 64'(in_ready), 64'(0));
         if (out_valid) seen = 1'b1;
         else if (busy) cnt++;
      end
      check("shift_done_seen", 64'(seen), 64'(1));
      check("shift_busy_cycles", 64'(cnt), 64'(63));
      @(posedge clk);
      #1;
      send(ALU_LSR, 64'h8000_0000_0000_0000, 64'd0, 6'd4, mk(64'h0800_0000_0000_0000, 4'b0000), w);
      for (int k = 0; k < 10; k++) @(posedge clk);
      #1;
      send(ALU_LSL, 64'h1234, 64'd0, 6'd0, mk(64'h1234, 4'b0000), w);
      @(negedge clk);
      check("shamt0_valid", 64'(out_valid), 64'(1));
      check("shamt0_busy", 64'(busy), 64'(0));
      @(posedge clk);
      #1;

      // Reset mid-shift aborts the op
      send_m(ALU_LSL, 64'd3, 64'd0, 6'd40);
      repeat (5) @(posedge clk);
      #1;
      check("midshift_busy", 64'(busy), 64'(1));
      rst_n = 1'b0;
      #1;
      check("midshift_rst_busy", 64'(busy), 64'(0));
      check("midshift_rst_valid", 64'(out_valid), 64'(0));
      sb_q.delete();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      cnt = 0;
      for (int k = 0; k < 60; k++) begin
         @(negedge clk);
         if (out_valid || busy) cnt++;
      end
      check("midshift_no_result", 64'(cnt), 64'(0));
      check("midshift_in_ready", 64'(in_ready), 64'(1));
      @(posedge clk);
      #1;
`else
      // Shift codes execute as ADD
      send(ALU_LSL, 64'd2, 64'd3, 6'd5, mk(64'd5, 4'b0000), w);
      send(ALU_LSR, 64'd2, 64'd3, 6'd5, mk(64'd5, 4'b0000), w);
      @(negedge clk);
      check("noshift_busy", 64'(busy), 64'(0));
      @(posedge clk);
      #1;
`endif

      // Random ops under random back-pressure
      rand_bp = 1'b1;
      for (int i = 0; i < 40; i++) begin
         send_m(codes[$urandom_range(0, 8)], {$urandom, $urandom}, {$urandom, $urandom},
                6'($urandom_range(0, 7)));
      end
      rand_bp = 1'b0;
      out_ready = 1'b1;
      for (int k = 0; k < 300 && sb_q.size() != 0; k++) @(posedge clk);
      repeat (2) @(posedge clk);
      check("drain_empty", 64'(sb_q.size()), 64'(0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
